// File: rtl/dmem_access_ctrl_if.sv
// Bus bundle for the data-memory access controller: core load/store port,
// external (debug/DMA) port and the single-port SRAM port.
interface dmem_access_ctrl_if #(
    parameter int ADDR_W = 10
);
    logic              core_req_i;
    logic              core_we_i;
    logic [31:0]       core_addr_i;
    logic [31:0]       core_wdata_i;
    logic [2:0]        core_type_i;
    logic              core_stall_o;
    logic              core_misalign_o;
    logic              core_rvalid_o;
    logic [31:0]       core_rdata_o;

    logic              ext_req_i;
    logic              ext_we_i;
    logic [31:0]       ext_addr_i;
    logic [31:0]       ext_wdata_i;
    logic [3:0]        ext_be_i;
    logic              ext_gnt_o;
    logic              ext_rvalid_o;
    logic [31:0]       ext_rdata_o;

    logic              sram_cs_o;
    logic              sram_we_o;
    logic [ADDR_W-1:0] sram_addr_o;
    logic [31:0]       sram_wdata_o;
    logic [3:0]        sram_be_o;
    logic [31:0]       sram_rdata_i;

    // Controller side
    modport slave (
        input  core_req_i, core_we_i, core_addr_i, core_wdata_i, core_type_i,
        output core_stall_o, core_misalign_o, core_rvalid_o, core_rdata_o,
        input  ext_req_i, ext_we_i, ext_addr_i, ext_wdata_i, ext_be_i,
        output ext_gnt_o, ext_rvalid_o, ext_rdata_o,
        output sram_cs_o, sram_we_o, sram_addr_o, sram_wdata_o, sram_be_o,
        input  sram_rdata_i
    );

    // Environment side: pipeline, external master and SRAM macro
    modport master (
        output core_req_i, core_we_i, core_addr_i, core_wdata_i, core_type_i,
        input  core_stall_o, core_misalign_o, core_rvalid_o, core_rdata_o,
        output ext_req_i, ext_we_i, ext_addr_i, ext_wdata_i, ext_be_i,
        input  ext_gnt_o, ext_rvalid_o, ext_rdata_o,
        input  sram_cs_o, sram_we_o, sram_addr_o, sram_wdata_o, sram_be_o,
        output sram_rdata_i
    );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller: arbitrates a single-port SRAM between the core
// load/store port and an external port, builds store lanes and aligns load data.
module dmem_access_ctrl #(
    parameter int ADDR_W       = 10,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              resetn,
    dmem_access_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    // Owner of the read response due in the current cycle
    typedef enum logic [1:0] {
        RD_NONE = 2'd0,
        RD_CORE = 2'd1,
        RD_EXT  = 2'd2
    } rd_state_t;

    rd_state_t         r_rd_state;
    rd_state_t         w_rd_state_next;
    logic [CNT_W-1:0]  r_starve_cnt;
    logic [1:0]        r_ld_off;
    logic [2:0]        r_ld_type;
    logic [31:0]       r_core_rdata;
    logic [31:0]       r_ext_rdata;

    logic              w_core_legal;
    logic              w_core_ok;
    logic              w_force;
    logic              w_core_gnt;
    logic              w_ext_gnt;
    logic [1:0]        w_core_off;
    logic [3:0]        w_core_be;
    logic [31:0]       w_core_wdata;
    logic [31:0]       w_shifted;
    logic [7:0]        w_ld_byte;
    logic [15:0]       w_ld_half;
    logic [31:0]       w_ld_data;
    logic              w_core_rvalid;
    logic              w_ext_rvalid;
    logic              w_unused;

    assign w_core_off = bus.core_addr_i[1:0];

    always_comb begin
        w_core_legal = 1'b0;
        case (bus.core_type_i)
            3'b000, 3'b100: w_core_legal = 1'b1;
            3'b001, 3'b101: w_core_legal = ~w_core_off[0];
            3'b010:         w_core_legal = (w_core_off == 2'b00);
            default:        w_core_legal = 1'b0;
        endcase
    end

    assign w_core_ok = bus.core_req_i & w_core_legal;

    // A starved ext request pre-empts the core; otherwise the core has priority.
    assign w_force    = bus.ext_req_i & (r_starve_cnt == STARVE_MAX);
    assign w_ext_gnt  = resetn & (w_force | (bus.ext_req_i & ~w_core_ok));
    assign w_core_gnt = resetn & ~w_force & w_core_ok;

    assign bus.core_misalign_o = bus.core_req_i & ~w_core_legal;
    assign bus.core_stall_o    = resetn & w_core_ok & ~w_core_gnt;
    assign bus.ext_gnt_o       = w_ext_gnt;

    // Store lanes: byte/half data is replicated so the enabled lanes see it.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign w_core_be[gi] =
                (bus.core_type_i[1:0] == 2'b00) ? (w_core_off == 2'(gi)) :
                (bus.core_type_i[1:0] == 2'b01) ? (w_core_off[1] == (gi >= 2)) :
                                                  1'b1;
            assign w_core_wdata[gi*8 +: 8] =
                (bus.core_type_i[1:0] == 2'b00) ? bus.core_wdata_i[7:0] :
                (bus.core_type_i[1:0] == 2'b01) ? bus.core_wdata_i[(gi%2)*8 +: 8] :
                                                  bus.core_wdata_i[gi*8 +: 8];
        end
    endgenerate

    always_comb begin
        bus.sram_cs_o    = 1'b0;
        bus.sram_we_o    = 1'b0;
        bus.sram_addr_o  = '0;
        bus.sram_wdata_o = '0;
        bus.sram_be_o    = 4'b0000;
        if (w_ext_gnt) begin
            bus.sram_cs_o    = 1'b1;
            bus.sram_we_o    = bus.ext_we_i;
            bus.sram_addr_o  = bus.ext_addr_i[ADDR_W+1:2];
            bus.sram_wdata_o = bus.ext_wdata_i;
            bus.sram_be_o    = bus.ext_we_i ? bus.ext_be_i : 4'b0000;
        end else if (w_core_gnt) begin
            bus.sram_cs_o    = 1'b1;
            bus.sram_we_o    = bus.core_we_i;
            bus.sram_addr_o  = bus.core_addr_i[ADDR_W+1:2];
            bus.sram_wdata_o = w_core_wdata;
            bus.sram_be_o    = bus.core_we_i ? w_core_be : 4'b0000;
        end
    end

    always_comb begin
        w_rd_state_next = RD_NONE;
        if (w_ext_gnt && !bus.ext_we_i) begin
            w_rd_state_next = RD_EXT;
        end else if (w_core_gnt && !bus.core_we_i) begin
            w_rd_state_next = RD_CORE;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_rd_state <= RD_NONE;
        end else begin
            r_rd_state <= w_rd_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_starve_cnt <= '0;
        end else if (bus.ext_req_i && !w_ext_gnt) begin
            r_starve_cnt <= (r_starve_cnt == STARVE_MAX) ? STARVE_MAX : r_starve_cnt + 1'b1;
        end else begin
            r_starve_cnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_ld_off  <= 2'b00;
            r_ld_type <= 3'b000;
        end else if (w_core_gnt && !bus.core_we_i) begin
            r_ld_off  <= w_core_off;
            r_ld_type <= bus.core_type_i;
        end
    end

    // Load alignment runs on the SRAM output the cycle after the grant.
    assign w_shifted = bus.sram_rdata_i >> {r_ld_off, 3'b000};
    assign w_ld_byte = w_shifted[7:0];
    assign w_ld_half = r_ld_off[1] ? bus.sram_rdata_i[31:16] : bus.sram_rdata_i[15:0];

    always_comb begin
        w_ld_data = bus.sram_rdata_i;
        case (r_ld_type)
            3'b000:  w_ld_data = {{24{w_ld_byte[7]}}, w_ld_byte};
            3'b100:  w_ld_data = {24'h000000, w_ld_byte};
            3'b001:  w_ld_data = {{16{w_ld_half[15]}}, w_ld_half};
            3'b101:  w_ld_data = {16'h0000, w_ld_half};
            default: w_ld_data = bus.sram_rdata_i;
        endcase
    end

    // A response pending when reset arrives is suppressed immediately.
    assign w_core_rvalid = resetn & (r_rd_state == RD_CORE);
    assign w_ext_rvalid  = resetn & (r_rd_state == RD_EXT);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_core_rdata <= '0;
            r_ext_rdata  <= '0;
        end else begin
            if (w_core_rvalid) begin
                r_core_rdata <= w_ld_data;
            end
            if (w_ext_rvalid) begin
                r_ext_rdata <= bus.sram_rdata_i;
            end
        end
    end

    assign bus.core_rvalid_o = w_core_rvalid;
    assign bus.core_rdata_o  = w_core_rvalid ? w_ld_data : r_core_rdata;
    assign bus.ext_rvalid_o  = w_ext_rvalid;
    assign bus.ext_rdata_o   = w_ext_rvalid ? bus.sram_rdata_i : r_ext_rdata;

    assign w_unused = ^{bus.ext_addr_i[31:ADDR_W+2], bus.ext_addr_i[1:0],
                        bus.core_addr_i[31:ADDR_W+2]};
endmodule
